// File: rtl/sddr_pkg.sv
// sddr_pkg
// Shared definitions for the SDDR PHY calibration engines. The write-leveling
// FSM uses the state encoding below; the read-leveling FSM will reuse it.
// No ports.
package sddr_pkg;

    typedef enum logic [3:0] {
        WL_IDLE   = 4'd0,
        WL_LOAD   = 4'd1,
        WL_STROBE = 4'd2,
        WL_SETTLE = 4'd3,
        WL_SAMPLE = 4'd4,
        WL_DECIDE = 4'd5,
        WL_INC    = 4'd6,
        WL_DONE   = 4'd7,
        WL_FAIL   = 4'd8
    } sddr_wl_state_t;

    // True while a sweep is running (LOAD through INC).
    function automatic logic wl_is_busy(input sddr_wl_state_t st);
        return (st == WL_LOAD)   || (st == WL_STROBE) || (st == WL_SETTLE) ||
               (st == WL_SAMPLE) || (st == WL_DECIDE) || (st == WL_INC);
    endfunction

endpackage

// File: rtl/sddr_wl_lane.sv
// sddr_wl_lane
// Per-byte-lane write-leveling state: majority-vote hit counter, seen_zero
// flag, locked flag and IDELAY tap. Sequenced by strobes from the top FSM.
// Ports:
//   clk        in   DDR clock
//   rst        in   synchronous reset, active-high
//   clear      in   start of a new sweep: clear all lane state
//   sample_en  in   accumulate dq into the hit counter (unlocked lanes only)
//   decide     in   evaluate the vote, update seen_zero/locked, clear hit counter
//   inc        in   advance the tap (unlocked lanes only)
//   dq         in   DQ feedback bit for this lane
//   tap        out  current tap
//   locked     out  lane has found its 0->1 edge
//   lock_nxt   out  locked as it will be after the current decide
//   at_max     out  tap has reached MAX_TAP
module sddr_wl_lane #(
    parameter int TAP_BITS = 5,
    parameter int MAX_TAP  = 31,
    parameter int SAMPLES  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                sample_en,
    input  logic                decide,
    input  logic                inc,
    input  logic                dq,
    output logic [TAP_BITS-1:0] tap,
    output logic                locked,
    output logic                lock_nxt,
    output logic                at_max
);

    localparam int HW = $clog2(SAMPLES + 1);
    localparam logic [HW-1:0]       HIT_THRESH = HW'(SAMPLES / 2);
    localparam logic [TAP_BITS-1:0] TAP_MAX    = TAP_BITS'(MAX_TAP);

    logic [HW-1:0] hit_cnt;
    logic          seen_zero;
    logic          hit;

    assign hit      = hit_cnt > HIT_THRESH;
    assign at_max   = tap == TAP_MAX;
    // The top FSM needs the post-decide lock state in the same cycle it
    // chooses between DONE, FAIL and INC.
    assign lock_nxt = locked | (decide & hit & seen_zero);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hit_cnt   <= '0;
            seen_zero <= 1'b0;
            locked    <= 1'b0;
            tap       <= '0;
        end else begin
            if (sample_en && !locked)
                hit_cnt <= hit_cnt + HW'(dq);
            if (decide) begin
                hit_cnt <= '0;
                if (!locked) begin
                    if (hit && seen_zero)
                        locked <= 1'b1;
                    else if (!hit)
                        seen_zero <= 1'b1;
                    // hit without a prior zero: sweep started inside the
                    // high region, so keep looking for a real rising edge.
                end
            end
            if (inc && !locked && !at_max)
                tap <= tap + 1'b1;
        end
    end

endmodule

// File: rtl/sddr_write_leveler.sv
// sddr_write_leveler
// Write-leveling calibration engine: sweeps a DQS output delay per byte lane
// until the DRAM's DQ feedback shows a filtered 0->1 transition.
// Ports:
//   in_ddr_clock_i  in   DDR clock, all logic on posedge
//   in_ddr_reset_i  in   synchronous reset, active-high
//   start_i         in   start calibration (IDLE/DONE/FAIL only)
//   dq_feedback_i   in   DQ feedback bit per lane
//   write_level_o   out  PHY leveling mode
//   dqs_strobe_o    out  one-cycle DQS drive request
//   delay_ld_o      out  one-cycle IDELAY reload-to-zero
//   delay_inc_o     out  per-lane one-cycle IDELAY CE
//   tap_o           out  current tap per lane, lane 0 in LSBs
//   locked_o        out  per-lane lock flag
//   busy_o          out  calibration in progress
//   done_o          out  all lanes locked
//   fail_o          out  some lane ran out of taps
//
// state  | meaning
// IDLE   | waiting for start_i
// LOAD   | reset PHY IDELAY taps to zero
// STROBE | issue one DQS strobe
// SETTLE | wait SETTLE_CYCLES for DQ feedback
// SAMPLE | accumulate feedback per unlocked lane
// DECIDE | majority vote, lock/seen_zero update, pick DONE/FAIL/INC
// INC    | advance taps of unlocked lanes
// DONE   | all lanes locked, results held
// FAIL   | a lane exhausted MAX_TAP, results held
module sddr_write_leveler
    import sddr_pkg::*;
#(
    parameter int LANES         = 2,
    parameter int TAP_BITS      = 5,
    parameter int MAX_TAP       = 31,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLES       = 4
) (
    input  logic                      in_ddr_clock_i,
    input  logic                      in_ddr_reset_i,
    input  logic                      start_i,
    input  logic [LANES-1:0]          dq_feedback_i,
    output logic                      write_level_o,
    output logic                      dqs_strobe_o,
    output logic                      delay_ld_o,
    output logic [LANES-1:0]          delay_inc_o,
    output logic [LANES*TAP_BITS-1:0] tap_o,
    output logic [LANES-1:0]          locked_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      fail_o
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int CW = $clog2(SAMPLES + 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLES - 1);

    sddr_wl_state_t state, state_nxt;
    logic [SW-1:0]  settle_cnt;
    logic [CW-1:0]  sample_cnt;
    logic           start_go;
    logic [LANES-1:0] lane_lock_nxt;
    logic [LANES-1:0] lane_at_max;
    logic           all_locked;
    logic           any_fail;

    assign start_go   = start_i && ((state == WL_IDLE) || (state == WL_DONE) || (state == WL_FAIL));
    assign all_locked = &lane_lock_nxt;
    assign any_fail   = |(~lane_lock_nxt & lane_at_max);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sddr_wl_lane #(
            .TAP_BITS (TAP_BITS),
            .MAX_TAP  (MAX_TAP),
            .SAMPLES  (SAMPLES)
        ) u_lane (
            .clk       (in_ddr_clock_i),
            .rst       (in_ddr_reset_i),
            .clear     (start_go),
            .sample_en (state == WL_SAMPLE),
            .decide    (state == WL_DECIDE),
            .inc       (state == WL_INC),
            .dq        (dq_feedback_i[l]),
            .tap       (tap_o[l*TAP_BITS +: TAP_BITS]),
            .locked    (locked_o[l]),
            .lock_nxt  (lane_lock_nxt[l]),
            .at_max    (lane_at_max[l])
        );
        assign delay_inc_o[l] = (state == WL_INC) && !locked_o[l];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WL_IDLE, WL_DONE, WL_FAIL: if (start_go) state_nxt = WL_LOAD;
            WL_LOAD:   state_nxt = WL_STROBE;
            WL_STROBE: state_nxt = WL_SETTLE;
            WL_SETTLE: if (settle_cnt == '0) state_nxt = WL_SAMPLE;
            WL_SAMPLE: state_nxt = (sample_cnt == SAMPLE_LAST) ? WL_DECIDE : WL_STROBE;
            WL_DECIDE: begin
                // Lock check first: a lane locking at MAX_TAP is a success.
                if (all_locked)    state_nxt = WL_DONE;
                else if (any_fail) state_nxt = WL_FAIL;
                else               state_nxt = WL_INC;
            end
            WL_INC:    state_nxt = WL_STROBE;
            default:   state_nxt = WL_IDLE;
        endcase
    end

    always_ff @(posedge in_ddr_clock_i) begin
        if (in_ddr_reset_i) begin
            state      <= WL_IDLE;
            settle_cnt <= '0;
            sample_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (start_go)
                sample_cnt <= '0;
            if (state == WL_STROBE)
                settle_cnt <= SETTLE_LOAD;
            else if (state == WL_SETTLE && settle_cnt != '0)
                settle_cnt <= settle_cnt - 1'b1;
            if (state == WL_SAMPLE)
                sample_cnt <= (sample_cnt == SAMPLE_LAST) ? '0 : sample_cnt + 1'b1;
        end
    end

    assign busy_o        = wl_is_busy(state);
    assign write_level_o = busy_o;
    assign dqs_strobe_o  = state == WL_STROBE;
    assign delay_ld_o    = state == WL_LOAD;
    assign done_o        = state == WL_DONE;
    assign fail_o        = state == WL_FAIL;

endmodule

// File: tb/tb_sddr_write_leveler.sv
module tb_sddr_write_leveler;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic [1:0] dq_feedback;
    logic       write_level_o, dqs_strobe_o, delay_ld_o, busy_o, done_o, fail_o;
    logic [1:0] delay_inc_o, locked_o;
    logic [9:0] tap_o;

    int checks = 0;
    int passed = 0;

    int ld_cnt = 0, inc0_cnt = 0, inc1_cnt = 0, strobe_cnt = 0;
    int edge0, edge1;
    bit noise;
    int noise_base;

    always #5 clk = ~clk;

    sddr_write_leveler dut (
        .in_ddr_clock_i (clk),
        .in_ddr_reset_i (rst),
        .start_i        (start_i),
        .dq_feedback_i  (dq_feedback),
        .write_level_o  (write_level_o),
        .dqs_strobe_o   (dqs_strobe_o),
        .delay_ld_o     (delay_ld_o),
        .delay_inc_o    (delay_inc_o),
        .tap_o          (tap_o),
        .locked_o       (locked_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .fail_o         (fail_o)
    );

    // DRAM model: feedback high once the lane's tap reaches its edge.
    // Noise flips the first strobe of every tap.
    always_comb begin
        dq_feedback[0] = int'(tap_o[4:0]) >= edge0;
        dq_feedback[1] = int'(tap_o[9:5]) >= edge1;
        if (noise && ((strobe_cnt - noise_base) % 4 == 1))
            dq_feedback = ~dq_feedback;
    end

    always @(posedge clk) begin
        if (delay_ld_o)     ld_cnt     <= ld_cnt + 1;
        if (delay_inc_o[0]) inc0_cnt   <= inc0_cnt + 1;
        if (delay_inc_o[1]) inc1_cnt   <= inc1_cnt + 1;
        if (dqs_strobe_o)   strobe_cnt <= strobe_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_end(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if (done_o || fail_o) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start_i = 1'b0;
        edge0 = 5;
        edge1 = 12;
        noise = 1'b0;
        noise_base = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({write_level_o, dqs_strobe_o, delay_ld_o, busy_o, done_o, fail_o} !== 6'b0) begin
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {write_level_o, dqs_strobe_o, delay_ld_o, busy_o, done_o, fail_o});
        end else passed++;
        checks++;
        if ({delay_inc_o, locked_o, tap_o} !== 14'b0) begin
            $display("FAIL reset_lanes: got inc=%b locked=%b tap=%h expected all 0",
                     delay_inc_o, locked_o, tap_o);
        end else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Runs a sweep with edges {5,12} and checks the standard lock result.
    task automatic sweep_lock(input string tag, input bit check_start);
        int ld0, i0, i1;
        bit to;
        ld0 = ld_cnt;
        i0 = inc0_cnt;
        i1 = inc1_cnt;
        do_start();
        if (check_start) begin
            checks++;
            if (delay_ld_o !== 1'b1 || busy_o !== 1'b1 || write_level_o !== 1'b1) begin
                $display("FAIL %s_load: got ld=%b busy=%b wl=%b expected 1 1 1",
                         tag, delay_ld_o, busy_o, write_level_o);
            end else passed++;
        end
        wait_end(to);
        checks++;
        if (to || done_o !== 1'b1 || fail_o !== 1'b0) begin
            $display("FAIL %s_done: got done=%b fail=%b timeout=%0d expected done=1 fail=0",
                     tag, done_o, fail_o, to);
        end else passed++;
        checks++;
        if (tap_o[4:0] !== 5'd5 || tap_o[9:5] !== 5'd12 || locked_o !== 2'b11) begin
            $display("FAIL %s_taps: got tap0=%0d tap1=%0d locked=%b expected 5 12 11",
                     tag, tap_o[4:0], tap_o[9:5], locked_o);
        end else passed++;
        checks++;
        if (ld_cnt - ld0 !== 1 || inc0_cnt - i0 !== 5 || inc1_cnt - i1 !== 12) begin
            $display("FAIL %s_pulses: got ld=%0d inc0=%0d inc1=%0d expected 1 5 12",
                     tag, ld_cnt - ld0, inc0_cnt - i0, inc1_cnt - i1);
        end else passed++;
        checks++;
        if (busy_o !== 1'b0 || write_level_o !== 1'b0) begin
            $display("FAIL %s_idle: got busy=%b wl=%b expected 0 0", tag, busy_o, write_level_o);
        end else passed++;
    endtask

    task automatic test_basic;
        edge0 = 5;
        edge1 = 12;
        sweep_lock("basic", 1'b1);
        // Results hold in DONE.
        repeat (10) @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || tap_o !== {5'd12, 5'd5}) begin
            $display("FAIL basic_hold: got done=%b tap=%h expected 1 %h", done_o, tap_o, {5'd12, 5'd5});
        end else passed++;
    endtask

    task automatic sweep_fail(input string tag, input int e0, input int e1, input logic [4:0] exp_t1);
        bit to;
        edge0 = e0;
        edge1 = e1;
        do_start();
        wait_end(to);
        checks++;
        if (to || fail_o !== 1'b1 || done_o !== 1'b0) begin
            $display("FAIL %s_fail: got fail=%b done=%b timeout=%0d expected fail=1 done=0",
                     tag, fail_o, done_o, to);
        end else passed++;
        checks++;
        if (tap_o[4:0] !== 5'd31 || tap_o[9:5] !== exp_t1 || locked_o !== 2'b10) begin
            $display("FAIL %s_taps: got tap0=%0d tap1=%0d locked=%b expected 31 %0d 10",
                     tag, tap_o[4:0], tap_o[9:5], locked_o, exp_t1);
        end else passed++;
    endtask

    task automatic test_fail_far;
        sweep_fail("far", 40, 3, 5'd3);
    endtask

    task automatic test_no_zero;
        sweep_fail("nozero", 0, 12, 5'd12);
    endtask

    task automatic test_noise;
        edge0 = 5;
        edge1 = 12;
        noise_base = strobe_cnt;
        noise = 1'b1;
        sweep_lock("noise", 1'b0);
        noise = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit found;
        edge0 = 5;
        edge1 = 12;
        do_start();
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (dqs_strobe_o && tap_o[9:5] == 5'd7) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            $display("FAIL rstmid_reach: got no strobe at tap 7 expected one");
        end else passed++;
        repeat (3) @(negedge clk);  // now inside SETTLE
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({write_level_o, dqs_strobe_o, delay_ld_o, busy_o, done_o, fail_o,
             delay_inc_o, locked_o, tap_o} !== 20'b0) begin
            $display("FAIL rstmid_outputs: got ctrl=%b inc=%b locked=%b tap=%h expected all 0",
                     {write_level_o, dqs_strobe_o, delay_ld_o, busy_o, done_o, fail_o},
                     delay_inc_o, locked_o, tap_o);
        end else passed++;
        repeat (30) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || dqs_strobe_o !== 1'b0) begin
            $display("FAIL rstmid_idle: got busy=%b strobe=%b expected 0 0", busy_o, dqs_strobe_o);
        end else passed++;
        sweep_lock("rstmid", 1'b1);
    endtask

    task automatic test_start_ignored;
        int ld0;
        bit found, to;
        edge0 = 5;
        edge1 = 12;
        ld0 = ld_cnt;
        do_start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dqs_strobe_o) begin
                found = 1'b1;
                break;
            end
        end
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        checks++;
        if (!found || delay_ld_o !== 1'b0 || busy_o !== 1'b1) begin
            $display("FAIL ignore_start: got found=%0d ld=%b busy=%b expected 1 0 1",
                     found, delay_ld_o, busy_o);
        end else passed++;
        wait_end(to);
        checks++;
        if (to || done_o !== 1'b1 || tap_o !== {5'd12, 5'd5} || ld_cnt - ld0 !== 1) begin
            $display("FAIL ignore_result: got done=%b tap=%h ld=%0d timeout=%0d expected 1 %h 1",
                     done_o, tap_o, ld_cnt - ld0, to, {5'd12, 5'd5});
        end else passed++;
    endtask

    task automatic test_back_to_back;
        do_start();
        checks++;
        if (tap_o !== 10'b0 || locked_o !== 2'b0 || done_o !== 1'b0 || delay_ld_o !== 1'b1) begin
            $display("FAIL b2b_clear: got tap=%h locked=%b done=%b ld=%b expected 0 0 0 1",
                     tap_o, locked_o, done_o, delay_ld_o);
        end else passed++;
        // Second sweep with different edges from cleared taps.
        edge0 = 2;
        edge1 = 9;
        begin
            bit to;
            wait_end(to);
            checks++;
            if (to || done_o !== 1'b1 || tap_o !== {5'd9, 5'd2} || locked_o !== 2'b11) begin
                $display("FAIL b2b_result: got done=%b tap=%h locked=%b timeout=%0d expected 1 %h 11",
                         done_o, tap_o, locked_o, to, {5'd9, 5'd2});
            end else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fail_far();
        test_no_zero();
        test_noise();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
